// File: rtl/qrd_row_feeder_if.sv
// Element stream into the QRD row feeder.
//   in_valid : source has an element on in_r/in_i
//   in_ready : feeder can take the element this cycle
//   in_r/in_i: signed real/imag parts, row-major order, col 4 = y
// master = element source, slave = feeder.
interface qrd_row_feeder_if #(
  parameter int W = 14
) ();
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_r;
  logic signed [W-1:0] in_i;

  modport master (output in_valid, output in_r, output in_i, input in_ready);
  modport slave  (input in_valid, input in_r, input in_i, output in_ready);
endinterface

// File: rtl/qrd_row_feeder.sv
// Input formatter in front of the QRD core. Buffers an augmented 4x5
// complex matrix [H | y] in one of two ping-pong banks, then drives the
// core's skewed row ports and start flags on the fixed 46-step schedule.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_if (slave)   : serial element stream (valid/ready)
//   core_ready      : core can take a new matrix, sampled at launch decision
//   row_in_N_r/i    : skewed row data to the core (registered)
//   row_in_N_f      : row start flags (registered)
//   busy            : a schedule is being issued (registered)
module qrd_row_feeder #(
  parameter int W        = 14,
  parameter int ROW3_OFS = 21,
  parameter int ROW4_OFS = 41,
  parameter int F2_OFS   = 2,
  parameter int F3_OFS   = 23
) (
  input  logic                clk,
  input  logic                rst,
  qrd_row_feeder_if.slave     in_if,
  input  logic                core_ready,
  output logic signed [W-1:0] row_in_1_r,
  output logic signed [W-1:0] row_in_1_i,
  output logic signed [W-1:0] row_in_2_r,
  output logic signed [W-1:0] row_in_2_i,
  output logic signed [W-1:0] row_in_3_r,
  output logic signed [W-1:0] row_in_3_i,
  output logic signed [W-1:0] row_in_4_r,
  output logic signed [W-1:0] row_in_4_i,
  output logic                row_in_1_f,
  output logic                row_in_2_f,
  output logic                row_in_3_f,
  output logic                busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [5:0] LAST_T = 6'd45;

  state_t         state_r, state_nxt_s;
  logic [5:0]     t_r, t_nxt_s;
  logic [1:0]     full_r, full_nxt_s;
  logic           wbank_r, rbank_r, rbank_nxt_s;
  logic [4:0]     wcnt_r;
  logic           wr_en_s, run_nxt_s;
  logic [5:0]     rel2_s, rel3_s, rel4_s;
  logic [2*W-1:0] d1_s, d2_s, d3_s, d4_s;
  logic           f1_s, f2_s, f3_s;

  // Each bank entry holds {real, imag}, indexed row*5 + col.
  logic [2*W-1:0] mem_r [0:1][0:19];

  assign in_if.in_ready = ~full_r[wbank_r];
  assign wr_en_s        = in_if.in_valid & ~full_r[wbank_r];

  // Element storage write port (no reset needed; full/wcnt gate its use).
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_r[wbank_r][wcnt_r] <= {in_if.in_r, in_if.in_i};
    end
  end

  // Load pointers: element count and write bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_r  <= 5'd0;
      wbank_r <= 1'b0;
    end else if (wr_en_s) begin
      if (wcnt_r == 5'd19) begin
        wcnt_r  <= 5'd0;
        wbank_r <= ~wbank_r;
      end else begin
        wcnt_r <= wcnt_r + 5'd1;
      end
    end
  end

  // State, schedule step, read bank and bank-full flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      t_r     <= 6'd0;
      rbank_r <= 1'b0;
      full_r  <= 2'b00;
    end else begin
      state_r <= state_nxt_s;
      t_r     <= t_nxt_s;
      rbank_r <= rbank_nxt_s;
      full_r  <= full_nxt_s;
    end
  end

  // Next state: launch decision, step advance, bank hand-over at the last step.
  always_comb begin
    state_nxt_s = state_r;
    t_nxt_s     = t_r;
    rbank_nxt_s = rbank_r;
    full_nxt_s  = full_r;
    // Completing a load marks the bank full; the write bank is never the
    // bank being issued, since a full bank refuses writes.
    if (wr_en_s && (wcnt_r == 5'd19)) begin
      full_nxt_s[wbank_r] = 1'b1;
    end else begin
      full_nxt_s = full_r;
    end
    case (state_r)
      IDLE: begin
        if (full_r[rbank_r] && core_ready) begin
          state_nxt_s = RUN;
          t_nxt_s     = 6'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (t_r == LAST_T) begin
          full_nxt_s[rbank_r] = 1'b0;
          rbank_nxt_s         = ~rbank_r;
          t_nxt_s             = 6'd0;
          // Back-to-back launch uses the registered full bit of the other bank.
          if (full_r[~rbank_r] && core_ready) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          t_nxt_s = t_r + 6'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        t_nxt_s     = 6'd0;
      end
    endcase
  end

  // Schedule lookup for the step that will be on the outputs next cycle.
  always_comb begin
    run_nxt_s = (state_nxt_s == RUN);
    rel2_s    = t_nxt_s - 6'd1;
    rel3_s    = t_nxt_s - 6'(ROW3_OFS);
    rel4_s    = t_nxt_s - 6'(ROW4_OFS);
    if (run_nxt_s && (t_nxt_s < 6'd5)) begin
      d1_s = mem_r[rbank_nxt_s][t_nxt_s[4:0]];
    end else begin
      d1_s = {(2*W){1'b0}};
    end
    if (run_nxt_s && (t_nxt_s >= 6'd1) && (rel2_s < 6'd5)) begin
      d2_s = mem_r[rbank_nxt_s][5'd5 + rel2_s[4:0]];
    end else begin
      d2_s = {(2*W){1'b0}};
    end
    if (run_nxt_s && (t_nxt_s >= 6'(ROW3_OFS)) && (rel3_s < 6'd5)) begin
      d3_s = mem_r[rbank_nxt_s][5'd10 + rel3_s[4:0]];
    end else begin
      d3_s = {(2*W){1'b0}};
    end
    if (run_nxt_s && (t_nxt_s >= 6'(ROW4_OFS)) && (rel4_s < 6'd5)) begin
      d4_s = mem_r[rbank_nxt_s][5'd15 + rel4_s[4:0]];
    end else begin
      d4_s = {(2*W){1'b0}};
    end
    f1_s = run_nxt_s && (t_nxt_s == 6'd0);
    f2_s = run_nxt_s && (t_nxt_s == 6'(F2_OFS));
    f3_s = run_nxt_s && (t_nxt_s == 6'(F3_OFS));
  end

  // Registered row data, flags and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      {row_in_1_r, row_in_1_i} <= {(2*W){1'b0}};
      {row_in_2_r, row_in_2_i} <= {(2*W){1'b0}};
      {row_in_3_r, row_in_3_i} <= {(2*W){1'b0}};
      {row_in_4_r, row_in_4_i} <= {(2*W){1'b0}};
      row_in_1_f <= 1'b0;
      row_in_2_f <= 1'b0;
      row_in_3_f <= 1'b0;
      busy       <= 1'b0;
    end else begin
      {row_in_1_r, row_in_1_i} <= d1_s;
      {row_in_2_r, row_in_2_i} <= d2_s;
      {row_in_3_r, row_in_3_i} <= d3_s;
      {row_in_4_r, row_in_4_i} <= d4_s;
      row_in_1_f <= f1_s;
      row_in_2_f <= f2_s;
      row_in_3_f <= f3_s;
      busy       <= run_nxt_s;
    end
  end

endmodule

// File: tb/tb_qrd_row_feeder.sv
// Directed bench for qrd_row_feeder: reset, single matrix, back-to-back,
// core backpressure, sparse input with extremes, both banks full and
// reset during a run with a partial load pending.
module tb_qrd_row_feeder;
  localparam int W = 14;

  logic clk = 1'b0;
  logic rst;
  logic core_ready;
  logic signed [W-1:0] r1r, r1i, r2r, r2i, r3r, r3i, r4r, r4i;
  logic f1, f2, f3, busy;

  always #5 clk = ~clk;

  qrd_row_feeder_if #(.W(W)) in_if ();

  qrd_row_feeder #(.W(W), .ROW3_OFS(21), .ROW4_OFS(41), .F2_OFS(2), .F3_OFS(23)) dut (
    .clk(clk), .rst(rst), .in_if(in_if), .core_ready(core_ready),
    .row_in_1_r(r1r), .row_in_1_i(r1i), .row_in_2_r(r2r), .row_in_2_i(r2i),
    .row_in_3_r(r3r), .row_in_3_i(r3i), .row_in_4_r(r4r), .row_in_4_i(r4i),
    .row_in_1_f(f1), .row_in_2_f(f2), .row_in_3_f(f3), .busy(busy)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int stalls   = 0;
  time last_hs = 0;
  time a_hs    = 0;
  time t_rel   = 0;
  logic signed [W-1:0] mats_r [0:7][0:19];
  logic signed [W-1:0] mats_i [0:7][0:19];

  function automatic logic [115:0] obs_vec();
    return {busy, f1, f2, f3, r1r, r1i, r2r, r2i, r3r, r3i, r4r, r4i};
  endfunction

  // Expected output vector at schedule step t of matrix m.
  function automatic logic [115:0] exp_vec(input int m, input int t);
    logic signed [W-1:0] e [0:7];
    for (int i = 0; i < 8; i++) e[i] = '0;
    if (t <= 4)             begin e[0] = mats_r[m][t];         e[1] = mats_i[m][t];         end
    if (t >= 1 && t <= 5)   begin e[2] = mats_r[m][5 + t - 1];  e[3] = mats_i[m][5 + t - 1];  end
    if (t >= 21 && t <= 25) begin e[4] = mats_r[m][10 + t - 21]; e[5] = mats_i[m][10 + t - 21]; end
    if (t >= 41 && t <= 45) begin e[6] = mats_r[m][15 + t - 41]; e[7] = mats_i[m][15 + t - 41]; end
    return {1'b1, (t == 0), (t == 2), (t == 23), e[0], e[1], e[2], e[3], e[4], e[5], e[6], e[7]};
  endfunction

  task automatic chk(input string tag, input logic [115:0] obs, input logic [115:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Present one element at a negedge, wait (bounded) for ready, hand it over.
  task automatic push(input int m, input int k, input int gap);
    int w;
    in_if.in_valid = 1'b1;
    in_if.in_r = mats_r[m][k];
    in_if.in_i = mats_i[m][k];
    w = 0;
    while (!in_if.in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    stalls += w;
    chk($sformatf("push_ready_m%0d_k%0d", m, k), 116'(in_if.in_ready), 116'd1);
    @(posedge clk);
    last_hs = $time;
    @(negedge clk);
    in_if.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic load(input int m, input bit sparse);
    for (int k = 0; k < 20; k++) push(m, k, sparse ? (k % 3) : 0);
  endtask

  task automatic wait_busy();
    int w;
    w = 0;
    while (!busy && w < 400) begin
      @(negedge clk);
      w++;
    end
  endtask

  // Check all 46 steps starting at the current negedge (C0); optionally drop core_ready.
  task automatic run_check(input int m, input int drop_at);
    for (int t = 0; t < 46; t++) begin
      if (t == drop_at) core_ready = 1'b0;
      chk($sformatf("m%0d_t%0d", m, t), obs_vec(), exp_vec(m, t));
      @(negedge clk);
    end
  endtask

  initial begin
    for (int k = 0; k < 20; k++) begin
      mats_r[0][k] = 14'(16 * (k / 5) + (k % 5));
      mats_i[0][k] = -14'(16 * (k / 5) + (k % 5));
      mats_r[1][k] = 14'(100 + 3 * k);   mats_i[1][k] = 14'(k - 50);
      mats_r[2][k] = 14'(-(200 + k));    mats_i[2][k] = 14'(7 * k);
      mats_r[3][k] = 14'(37 * k - 300);  mats_i[3][k] = 14'(-11 * k);
      mats_r[4][k] = 14'($urandom);      mats_i[4][k] = 14'($urandom);
      mats_r[5][k] = 14'(1000 + k);      mats_i[5][k] = 14'(-1000 - k);
      mats_r[6][k] = 14'(2000 + 5 * k);  mats_i[6][k] = 14'(k * k);
      mats_r[7][k] = 14'(-3000 + 9 * k); mats_i[7][k] = 14'(4000 - k);
    end
    mats_r[4][0]  = 14'sd8191;  mats_i[4][0]  = -14'sd8192;
    mats_r[4][1]  = -14'sd8192; mats_i[4][1]  = 14'sd8191;
    mats_r[4][2]  = -14'sd8191; mats_i[4][2]  = -14'sd8191;
    mats_r[4][19] = 14'sd8191;  mats_i[4][19] = -14'sd8192;

    in_if.in_valid = 1'b0;
    in_if.in_r = '0;
    in_if.in_i = '0;
    core_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_out", obs_vec(), 116'd0);
    chk("reset_ready", 116'(in_if.in_ready), 116'd1);

    // Single matrix, minimum latency.
    core_ready = 1'b1;
    load(0, 1'b0);
    chk("single_pre_c0", obs_vec(), 116'd0);
    wait_busy();
    chk("single_c0", 116'($time), 116'(last_hs + 15));
    run_check(0, -1);
    chk("single_end", obs_vec(), 116'd0);

    // Back-to-back: A then B loaded continuously.
    fork
      begin
        load(1, 1'b0);
        a_hs = last_hs;
        stalls = 0;
        load(2, 1'b0);
        chk("b2b_b_no_stall", 116'(stalls), 116'd0);
      end
      begin
        wait_busy();
        chk("b2b_a_c0", 116'($time), 116'(a_hs + 15));
        run_check(1, -1);
        run_check(2, -1);
        chk("b2b_end", obs_vec(), 116'd0);
      end
    join

    // Backpressure: matrix waits 30 cycles, core_ready dropped at C0+10.
    core_ready = 1'b0;
    load(3, 1'b0);
    for (int i = 0; i < 30; i++) begin
      chk($sformatf("bp_idle_%0d", i), obs_vec(), 116'd0);
      @(negedge clk);
    end
    core_ready = 1'b1;
    t_rel = $time;
    wait_busy();
    chk("bp_c0", 116'($time), 116'(t_rel + 10));
    run_check(3, 10);
    chk("bp_end", obs_vec(), 116'd0);

    // Sparse input with extreme values.
    core_ready = 1'b1;
    load(4, 1'b1);
    wait_busy();
    chk("sparse_c0", 116'($time), 116'(last_hs + 15));
    run_check(4, -1);
    chk("sparse_end", obs_vec(), 116'd0);

    // Both banks full while core is not ready.
    core_ready = 1'b0;
    load(5, 1'b0);
    load(6, 1'b0);
    chk("full_ready_low", 116'(in_if.in_ready), 116'd0);
    chk("full_idle", obs_vec(), 116'd0);
    core_ready = 1'b1;
    t_rel = $time;
    wait_busy();
    chk("full_c0", 116'($time), 116'(t_rel + 10));
    chk("full_ready_in_run", 116'(in_if.in_ready), 116'd0);
    run_check(5, -1);
    chk("full_ready_back", 116'(in_if.in_ready), 116'd1);
    run_check(6, -1);
    chk("full_end", obs_vec(), 116'd0);

    // Reset mid-run with a partial second load pending.
    core_ready = 1'b1;
    load(0, 1'b0);
    wait_busy();
    repeat (10) @(negedge clk);
    for (int k = 0; k < 7; k++) push(7, k, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_run_out", obs_vec(), 116'd0);
    chk("rst_run_ready", 116'(in_if.in_ready), 116'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_run_idle_%0d", i), obs_vec(), 116'd0);
    end
    load(7, 1'b0);
    wait_busy();
    chk("rst_reload_c0", 116'($time), 116'(last_hs + 15));
    run_check(7, -1);
    chk("rst_reload_end", obs_vec(), 116'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
